// File: rtl/pipe_hold_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and its requesters/consumers.
// Signal suffixes are relative to the controller, which takes the slave side.
interface pipe_hold_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             jump_flag_i;
    logic [31:0]      jump_addr_i;
    logic             hold_ex_i;
    logic             hold_rib_i;
    logic             hold_clint_i;
    logic             load_use_i;
    logic             jump_flag_o;
    logic [31:0]      jump_addr_o;
    logic [2:0]       hold_flag_o;
    logic             stall_flag_o;
    logic             timeout_o;
    logic [CNT_W-1:0] hold_cnt_o;

    modport master (
        output jump_flag_i, jump_addr_i, hold_ex_i, hold_rib_i, hold_clint_i, load_use_i,
        input  jump_flag_o, jump_addr_o, hold_flag_o, stall_flag_o, timeout_o, hold_cnt_o
    );

    modport slave (
        input  jump_flag_i, jump_addr_i, hold_ex_i, hold_rib_i, hold_clint_i, load_use_i,
        output jump_flag_o, jump_addr_o, hold_flag_o, stall_flag_o, timeout_o, hold_cnt_o
    );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline sequencer: arbitrates hold requests, passes jump redirects through,
// stretches flushes, times load-use stalls, counts hold cycles and watches for stuck holds.
module pipe_hold_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned CNT_W        = 32
) (
    input logic             clk,
    input logic             rst,
    pipe_hold_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        STALL = 2'd2
    } state_e;

    localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned SW = $clog2(STALL_CYCLES + 1);
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          FLUSH_EXT  = (FLUSH_CYCLES > 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LOAD = SW'(STALL_CYCLES);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] req_lvl;
    logic [1:0] hold_lvl;
    logic       jump_acc;
    logic       stall_acc;
    logic       stall_now;
    logic       holding;
    logic       wd_hit;

    always_comb begin
        req_lvl = 2'd0;
        if (bus.hold_clint_i || bus.jump_flag_i || bus.hold_ex_i) begin
            req_lvl = 2'd3;
        end else if (bus.hold_rib_i) begin
            req_lvl = 2'd1;
        end
        jump_acc  = bus.jump_flag_i && !bus.hold_clint_i;
        hold_lvl  = (state_q == FLUSH) ? 2'd3 : req_lvl;
        holding   = (hold_lvl != 2'd0);
        stall_acc = (state_q == RUN) && bus.load_use_i && (req_lvl == 2'd0);
        stall_now = !jump_acc && (stall_acc || (state_q == STALL));
        wd_hit    = holding && (wd_q == WD_LAST);
    end

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        stall_d = stall_q;
        unique case (state_q)
            RUN: begin
                if (jump_acc) begin
                    if (FLUSH_EXT) begin
                        state_d = FLUSH;
                        flush_d = FLUSH_LOAD;
                    end
                end else if (stall_acc) begin
                    state_d = STALL;
                    stall_d = STALL_LOAD;
                end
            end
            FLUSH: begin
                if (jump_acc) begin
                    flush_d = FLUSH_LOAD;
                end else if (flush_q <= FW'(1)) begin
                    state_d = RUN;
                    flush_d = '0;
                end else begin
                    flush_d = flush_q - FW'(1);
                end
            end
            STALL: begin
                // A jump discards the hazard; any other pending hold freezes the stall timer.
                if (jump_acc) begin
                    stall_d = '0;
                    if (FLUSH_EXT) begin
                        state_d = FLUSH;
                        flush_d = FLUSH_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else if (req_lvl == 2'd0) begin
                    if (stall_q <= SW'(1)) begin
                        state_d = RUN;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q - SW'(1);
                    end
                end
            end
            default: begin
                state_d = RUN;
                flush_d = '0;
                stall_d = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        wd_d  = '0;
        if (holding) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            wd_d = wd_hit ? '0 : wd_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            flush_q <= '0;
            stall_q <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            stall_q <= stall_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by reset so the pipeline sees no control activity while held in reset.
    assign bus.jump_flag_o  = rst && jump_acc;
    assign bus.jump_addr_o  = (rst && jump_acc) ? bus.jump_addr_i : '0;
    assign bus.hold_flag_o  = rst ? {1'b0, hold_lvl} : 3'd0;
    assign bus.stall_flag_o = rst && stall_now;
    assign bus.timeout_o    = rst && wd_hit;
    assign bus.hold_cnt_o   = rst ? cnt_q : '0;

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
Central pipeline sequencer that drives the hold, stall and redirect controls consumed by pc_reg, if_id and id_ex. It arbitrates hold requests from ex, the bus (rib) and clint and issues jump redirects. It extends each jump flush over a configurable number of cycles to cover fetch latency, and times load-use stalls with a counter. It also keeps a saturating hold-cycle counter and a hold-timeout watchdog.

Parameters:
FLUSH_CYCLES, 2, total cycles Hold_Id is asserted per accepted jump (>=1)
STALL_CYCLES, 1, cycles stall_flag_o is held per accepted load-use request (>=1)
TIMEOUT, 1024, consecutive non-zero hold cycles before timeout_o pulses
CNT_W, 32, width of the hold performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
jump_flag_i  in  1  ex requests redirect (branch taken / mispredict)
jump_addr_i  in  32  redirect target
hold_ex_i  in  1  ex multi-cycle op (mul/div) busy
hold_rib_i  in  1  bus arbiter has granted away the fetch port
hold_clint_i  in  1  clint interrupt entry/exit in progress
load_use_i  in  1  id detects a load-use hazard
jump_flag_o  out  1  redirect to pc_reg
jump_addr_o  out  32  redirect target to pc_reg
hold_flag_o  out  3  0=None, 1=Hold_Pc, 2=Hold_If, 3=Hold_Id
stall_flag_o  out  1  freeze if_id contents
timeout_o  out  1  one-cycle pulse on hold watchdog expiry
hold_cnt_o  out  CNT_W  saturating count of cycles with hold_flag_o!=0

Behaviour:
- Reset (rst==0 at posedge): state=RUN, all counters 0. While in reset, outputs are jump_flag_o=0, jump_addr_o=0, hold_flag_o=0, stall_flag_o=0, timeout_o=0, hold_cnt_o=0.
- FSM states: RUN, FLUSH, STALL. flush_cnt and stall_cnt are internal down-counters.
- Combinational request level, highest wins:
  - hold_clint_i -> 3
  - jump_flag_i -> 3
  - hold_ex_i -> 3
  - hold_rib_i -> 1
  - else 0
- hold_flag_o = max(request level, 3 if state==FLUSH, else 0).
- Jump accept:
  - jump_flag_i=1 and hold_clint_i=0 in any state.
  - Same cycle: jump_flag_o=1 and jump_addr_o=jump_addr_i (zero-latency pass-through).
  - Otherwise jump_flag_o=0 and jump_addr_o=0.
  - hold_clint_i=1 masks the jump; clint owns the redirect.
- RUN -> FLUSH: on jump accept when FLUSH_CYCLES>1; flush_cnt <= FLUSH_CYCLES-1.
- FLUSH: flush_cnt decrements each cycle; at 1 -> RUN. A new jump accept in FLUSH reloads flush_cnt (no stacking).
- RUN -> STALL: load_use_i=1 with no jump accept and request level 0; stall_cnt <= STALL_CYCLES.
  - stall_flag_o=1 in the accept cycle and while state==STALL.
  - stall_cnt decrements; when stall_cnt==1 -> RUN.
  - load_use_i is ignored while in STALL.
- STALL + jump accept: the stall aborts. stall_flag_o=0 that cycle, and the FSM goes to FLUSH (or RUN if FLUSH_CYCLES==1). A jump kills the hazard.
- STALL + hold_ex_i/hold_rib_i: stall_flag_o stays 1 and stall_cnt freezes (no decrement).
- load_use_i while request level != 0 in RUN: not accepted. id re-asserts the request next cycle.
- hold_cnt_o: +1 each cycle hold_flag_o!=0; saturates at all-ones.
- Watchdog:
  - wd_cnt counts consecutive cycles with hold_flag_o!=0 and clears to 0 on any cycle with hold_flag_o==0.
  - When wd_cnt reaches TIMEOUT-1 while still holding: timeout_o=1 for one cycle, then wd_cnt wraps to 0.
- Reset mid-FLUSH/STALL returns to RUN immediately; no residual hold next cycle.

Test Plan:
- Idle reset release, all requests 0 for 10 cycles -> hold_flag_o=0, stall_flag_o=0, hold_cnt_o=0 throughout.
- jump_flag_i=1 for 1 cycle, jump_addr_i=0x0000_0100, FLUSH_CYCLES=2 -> that cycle jump_flag_o=1, jump_addr_o=0x100, hold_flag_o=3; next cycle hold_flag_o=3, jump_flag_o=0; following cycle 0; hold_cnt_o=2.
- load_use_i=1 for 1 cycle, STALL_CYCLES=2 -> stall_flag_o=1 for 3 cycles (accept + 2 STALL), hold_flag_o=0; load_use_i pulse during STALL has no effect.
- STALL active, jump_flag_i=1 -> stall_flag_o=0 same cycle, hold_flag_o=3 for FLUSH_CYCLES cycles; simultaneous hold_clint_i=1 with jump_flag_i=1 -> jump_flag_o=0, hold_flag_o=3.
- hold_rib_i and hold_ex_i together -> hold_flag_o=3; hold_rib_i alone -> 1; hold_rib_i held 1024 cycles, TIMEOUT=1024 -> timeout_o pulses once on cycle 1024; drop the hold 1 cycle, re-assert -> count restarts.
- Reset asserted mid-FLUSH -> next cycle after release hold_flag_o=0, state RUN; hold_cnt_o forced near all-ones (CNT_W=4) -> saturates at 15.
